pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: MemRead_id_ex  in  1  load instruction in EX.
REQ-004 SHALL have: rt_id_ex  in  5  load destination in EX.
REQ-005 SHALL have: rs_if_id, rt_if_id  in  5 each  source registers of instruction in ID.
REQ-006 SHALL have: Jump_id  in  2  nonzero = jump decoded in ID.
REQ-007 SHALL have: branch_taken_ex  in  1  taken branch resolved in EX.
REQ-008 SHALL have: ram_busy  in  1  data memory not ready this cycle.
REQ-009 SHALL have: halt_mem_wb  in  1  halt instruction reached WB.
REQ-010 SHALL have outputs stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb  1 each  hold corresponding register.
REQ-011 SHALL have outputs flush_if_id, flush_id_ex  1 each  load bubble (all-zero controls) into register.
REQ-012 SHALL have: state  out  2  RUN=0, MEM_WAIT=1, HALTED=2.
REQ-013 SHALL have: halted  out  1  high iff state==HALTED.
REQ-014 SHALL have: stall_count  out  16  cycles with stall_pc asserted.

Function
REQ-015 SHALL compute stall/flush outputs combinationally from state and inputs; state and stall_count registered.
REQ-016 SHALL define load_use = MemRead_id_ex & (rt_id_ex!=0) & (rt_id_ex==rs_if_id | rt_id_ex==rt_if_id).
REQ-017 SHALL apply priority: HALTED > halt_mem_wb > ram_busy > branch_taken_ex > load_use > Jump_id; exactly one rule active per cycle.
REQ-018 SHALL, in state HALTED or with halt_mem_wb=1, assert all five stalls, both flushes 0.
REQ-019 SHALL, when ram_busy=1, assert all five stalls, both flushes 0.
REQ-020 SHALL, on branch_taken_ex, assert flush_if_id and flush_id_ex, all stalls 0.
REQ-021 SHALL, on load_use, assert stall_pc, stall_if_id, flush_id_ex; others 0 (one-cycle bubble).
REQ-022 SHALL, on Jump_id!=0 alone, assert flush_if_id only.
REQ-023 SHALL, with no rule active, drive all stalls and flushes 0.
REQ-024 SHALL transition RUN->MEM_WAIT when ram_busy=1; MEM_WAIT->RUN when ram_busy=0; any state->HALTED when halt_mem_wb=1; HALTED exits only via rst.
REQ-025 SHALL increment stall_count on each edge where stall_pc=1 and state!=HALTED, saturating at 16'hFFFF.
REQ-026 SHALL treat load_use with rt_id_ex=0 as no hazard.
REQ-027 SHALL, on simultaneous load_use and Jump_id, suppress flush_if_id (jump re-decoded after stall).

Reset
REQ-028 SHALL, while rst=1, force state=RUN, stall_count=0, halted=0, all stalls and flushes 0, regardless of clk.
REQ-029 SHALL, on rst asserted mid-MEM_WAIT or HALTED, return to RUN immediately, first active edge after release evaluated normally.

Verification
REQ-030 load in EX rt=5, ID rs=5 -> one cycle stall_pc=stall_if_id=flush_id_ex=1, stall_count 0->1.
REQ-031 ram_busy high 3 cycles -> all stalls 1 three cycles, state=1 during, back to 0 after, stall_count +3.
REQ-032 branch_taken_ex=1 with load_use=1 -> flush_if_id=flush_id_ex=1, stalls 0, stall_count unchanged.
REQ-033 halt_mem_wb pulse -> state=2, halted=1, all stalls 1 indefinitely, stall_count frozen; rst -> state=0.
REQ-034 ram_busy held 70000 cycles -> stall_count saturates at 16'hFFFF.
REQ-035 load rt=0 matching rs=0, Jump_id=2'b01 -> flush_if_id=1 only, no stall.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard and stall/flush controller for a 5-stage pipeline
//
// Purpose: decides each cycle which pipeline registers hold (stall_*) and which
// load a bubble (flush_*), tracks a RUN / MEM_WAIT / HALTED state, and counts
// cycles in which the PC was held.
//
// Ports:
//   clk              in   1   clock, rising edge
//   rst              in   1   asynchronous active-high reset
//   MemRead_id_ex    in   1   load instruction in EX
//   rt_id_ex         in   5   load destination register in EX
//   rs_if_id         in   5   source register rs of instruction in ID
//   rt_if_id         in   5   source register rt of instruction in ID
//   Jump_id          in   2   nonzero when a jump is decoded in ID
//   branch_taken_ex  in   1   taken branch resolved in EX
//   ram_busy         in   1   data memory not ready this cycle
//   halt_mem_wb      in   1   halt instruction reached WB
//   stall_pc .. stall_mem_wb  out 1 each  hold the corresponding register
//   flush_if_id, flush_id_ex  out 1 each  load a bubble into the register
//   state            out  2   RUN=0, MEM_WAIT=1, HALTED=2
//   halted           out  1   high iff state is HALTED
//   stall_count      out  16  saturating count of cycles with stall_pc set

module pipeline_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_id_ex,
  input  logic [4:0]  rt_id_ex,
  input  logic [4:0]  rs_if_id,
  input  logic [4:0]  rt_if_id,
  input  logic [1:0]  Jump_id,
  input  logic        branch_taken_ex,
  input  logic        ram_busy,
  input  logic        halt_mem_wb,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        stall_id_ex,
  output logic        stall_ex_mem,
  output logic        stall_mem_wb,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic [1:0]  state,
  output logic        halted,
  output logic [15:0] stall_count
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALTED   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        load_use;

  // Register 0 is hardwired to zero, so a load into it never creates a hazard.
  assign load_use = MemRead_id_ex && (rt_id_ex != 5'd0) &&
                    ((rt_id_ex == rs_if_id) || (rt_id_ex == rt_if_id));

  // Priority chain: HALTED/halt > ram_busy > branch > load-use > jump.
  // Outputs are gated by rst so they read zero for the whole reset period.
  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    stall_mem_wb = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    if (!rst) begin
      if ((state_q == ST_HALTED) || halt_mem_wb || ram_busy) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
        stall_mem_wb = 1'b1;
      end else if (branch_taken_ex) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (load_use) begin
        // A jump in ID is left in place and re-decoded after the bubble,
        // so flush_if_id stays low here.
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (Jump_id != 2'b00) begin
        flush_if_id = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (halt_mem_wb || (state_q == ST_HALTED)) begin
      state_d = ST_HALTED;
    end else if (ram_busy) begin
      state_d = ST_MEM_WAIT;
    end else begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_pc && (state_q != ST_HALTED) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state       = state_q;
  assign halted      = (state_q == ST_HALTED);
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl

module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic [4:0]  rt_ex = 5'd0;
  logic [4:0]  rs_id = 5'd0;
  logic [4:0]  rt_id = 5'd0;
  logic [1:0]  jump = 2'd0;
  logic        br = 1'b0;
  logic        busy = 1'b0;
  logic        halt = 1'b0;

  logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic        flush_if_id, flush_id_ex;
  logic [1:0]  state;
  logic        halted;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk(clk), .rst(rst),
    .MemRead_id_ex(mem_read), .rt_id_ex(rt_ex),
    .rs_if_id(rs_id), .rt_if_id(rt_id),
    .Jump_id(jump), .branch_taken_ex(br),
    .ram_busy(busy), .halt_mem_wb(halt),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .state(state), .halted(halted), .stall_count(stall_count)
  );

  typedef struct {
    string       tag;
    logic [25:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: mode 0=running, 1=waiting on memory, 2=halted.
  int m_mode = 0;
  int m_cnt  = 0;

  // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, flush_if_id, flush_id_ex}
  function automatic logic [6:0] rule_out();
    logic hazard;
    hazard = mem_read && (rt_ex != 0) && (rt_ex == rs_id || rt_ex == rt_id);
    if (rst)                     return 7'b0000000;
    if (m_mode == 2 || halt)     return 7'b1111100;
    if (busy)                    return 7'b1111100;
    if (br)                      return 7'b0000011;
    if (hazard)                  return 7'b1100001;
    if (jump != 0)               return 7'b0000010;
    return 7'b0000000;
  endfunction

  task automatic step(input logic r, input logic mr, input logic [4:0] rte,
                      input logic [4:0] rsi, input logic [4:0] rti,
                      input logic [1:0] j, input logic b, input logic bz,
                      input logic h, input string tag);
    logic [6:0] o;
    exp_t e;
    @(posedge clk);
    if (!rst) begin
      o = rule_out();
      if (o[6] && m_mode != 2 && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (halt || m_mode == 2) m_mode = 2;
      else if (busy)           m_mode = 1;
      else                     m_mode = 0;
    end
    #1;
    rst = r; mem_read = mr; rt_ex = rte; rs_id = rsi; rt_id = rti;
    jump = j; br = b; busy = bz; halt = h;
    if (r) begin
      m_mode = 0;
      m_cnt  = 0;
    end
    o = rule_out();
    e.tag = tag;
    e.exp = {o, 2'(m_mode), (m_mode == 2), 16'(m_cnt)};
    sb_q.push_back(e);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [25:0] act;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      act = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
             flush_if_id, flush_id_ex, state, halted, stall_count};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got stalls/flushes=%b state=%0d halted=%b count=%0d, expected stalls/flushes=%b state=%0d halted=%b count=%0d",
                 e.tag, act[25:19], act[18:17], act[16], act[15:0],
                 e.exp[25:19], e.exp[18:17], e.exp[16], e.exp[15:0]);
      end
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: cycle budget expired, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held, with hazards present to show outputs are gated
    step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 2'd1, 1'b1, 1'b1, 1'b1, "reset_hold");
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, "reset_hold2");
    idle("reset_release");

    // load-use bubble
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, "load_use");
    idle("after_load_use");

    // memory busy three cycles
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0, "ram_busy");
    idle("busy_done");
    idle("busy_done2");

    // branch outranks load-use
    step(1'b0, 1'b1, 5'd7, 5'd0, 5'd7, 2'd0, 1'b1, 1'b0, 1'b0, "branch_over_lu");
    // load into r0 is not a hazard; jump flushes alone
    step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0, "rt0_jump");
    // load-use suppresses the jump flush
    step(1'b0, 1'b1, 5'd9, 5'd9, 5'd9, 2'd2, 1'b0, 1'b0, 1'b0, "lu_with_jump");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd3, 1'b0, 1'b0, 1'b0, "jump_only");

    // halt, then remains halted, then async reset out of it
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, "halt_pulse");
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 2'd1, 1'b1, 1'b0, 1'b0, "halted_hold");
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, "reset_from_halt");
    idle("run_after_halt");

    // async reset during memory wait
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0, "busy_before_rst");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0, "busy_before_rst2");
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0, "reset_from_wait");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0, "busy_after_rst");
    idle("idle_after_rst");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 59) == 0),
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
           1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 79) == 0),
           "random");
    end

    // saturation of the stall counter
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, "reset_before_sat");
    for (int i = 0; i < 70000; i++)
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0, "saturate");
    idle("sat_done");
    idle("sat_done2");

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
